// File: rtl/sa_instr_sequencer.sv
// Host-to-core instruction sequencer: FIFO-buffered issue, RUN/finish handshake
// with timeout watchdog, and indexed write-back forwarding.
module sa_instr_sequencer #(
  parameter int         BIT_INSTR = 32,
  parameter int         BIT_PSUM  = 32,
  parameter int         DEPTH     = 8,
  parameter int         IDX_W     = 8,
  parameter int         TIMEOUT   = 4096,
  parameter logic [3:0] OP_RUN    = 4'hF
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 i_Host_Valid,
  input  logic [BIT_INSTR-1:0] i_Host_Instr,
  output logic                 o_Host_Ready,
  output logic [BIT_INSTR-1:0] o_Instr_Out,
  input  logic                 i_Instr_Flag,
  input  logic                 i_Flag_Finish,
  input  logic                 i_Valid_WB,
  input  logic [BIT_PSUM-1:0]  i_Data_WB,
  output logic                 o_Res_Valid,
  output logic [BIT_PSUM-1:0]  o_Res_Data,
  output logic [IDX_W-1:0]     o_Res_Idx,
  output logic                 o_Done,
  output logic                 o_Busy,
  output logic                 o_Err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ISSUE, WAIT_FIN, HALT} state_t;

  state_t               state;
  logic [BIT_INSTR-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [IDX_W-1:0]     idx;
  logic [TW-1:0]        tcnt;
  logic                 push, pop;
  logic [BIT_INSTR-1:0] head;

  assign o_Host_Ready = (count != CW'(DEPTH));
  assign push         = i_Host_Valid && o_Host_Ready;
  assign pop          = (state == ISSUE) && (count != '0) && i_Instr_Flag;
  assign head         = mem[rd_ptr];
  assign o_Busy       = (count != '0) || (state == WAIT_FIN);

  // Storage needs no reset: emptiness is tracked by count alone.
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= i_Host_Instr;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state       <= ISSUE;
      o_Instr_Out <= '0;
      o_Done      <= 1'b0;
      o_Err       <= 1'b0;
      o_Res_Valid <= 1'b0;
      o_Res_Data  <= '0;
      o_Res_Idx   <= '0;
      idx         <= '0;
      tcnt        <= '0;
    end else begin
      o_Instr_Out <= pop ? head : '0;
      o_Done      <= 1'b0;
      o_Res_Valid <= i_Valid_WB;
      if (i_Valid_WB) begin
        o_Res_Data <= i_Data_WB;
        o_Res_Idx  <= idx;
        idx        <= idx + IDX_W'(1);
      end
      case (state)
        ISSUE:
          // A RUN issue clears the index even if a write-back lands in the same cycle.
          if (pop && head[BIT_INSTR-1 -: 4] == OP_RUN) begin
            state <= WAIT_FIN;
            idx   <= '0;
            tcnt  <= '0;
          end
        WAIT_FIN:
          if (i_Flag_Finish) begin
            o_Done <= 1'b1;
            state  <= ISSUE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            o_Err <= 1'b1;
            state <= HALT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        default: ;
      endcase
    end
  end
endmodule
